hub75_scan_driver: RTL and testbench

- Reader-side counterpart to the pixel-write interface. It scans a 64x64 12-bit framebuffer through a synchronous read port.
- Drives a 1/32-scan HUB75 LED panel: row-pair addressing, 64-column shift, latch and output-enable.
- Produces 4-bit-per-channel brightness by binary-coded modulation over 4 bit planes.
- Sits between the framebuffer read port and the panel connector pins.

---
 rtl/hub75_scan_driver_if.sv | 32 +++
 rtl/hub75_scan_driver.sv | 182 ++++++++++++++++++
 tb/tb_hub75_scan_driver.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/hub75_scan_driver_if.sv
// Framebuffer read port and HUB75 panel pins of the scan driver.
// The driver takes the master side; framebuffer and panel sit on the slave side.
interface hub75_scan_driver_if;
    logic [5:0]  rd_x;
    logic [5:0]  rd_y;
    logic [11:0] rd_color;
    logic        r1;
    logic        g1;
    logic        b1;
    logic        r2;
    logic        g2;
    logic        b2;
    logic [4:0]  addr;
    logic        panel_clk;
    logic        panel_lat;
    logic        panel_oe_n;
    logic        frame_start;

    modport master (
        output rd_x, rd_y,
        input  rd_color,
        output r1, g1, b1, r2, g2, b2, addr,
        output panel_clk, panel_lat, panel_oe_n, frame_start
    );

    modport slave (
        input  rd_x, rd_y,
        output rd_color,
        input  r1, g1, b1, r2, g2, b2, addr,
        input  panel_clk, panel_lat, panel_oe_n, frame_start
    );
endinterface

// File: rtl/hub75_scan_driver.sv
// 1/32-scan HUB75 driver: reads a 64x64 12-bit framebuffer and shows it with
// 4-plane binary-coded modulation; every panel and read-port output is registered.
module hub75_scan_driver #(
    parameter int CLK_DIV      = 2,
    parameter int BASE_ON      = 64,
    parameter int BLANK_CYCLES = 4
) (
    input  logic                clk,
    input  logic                reset,
    hub75_scan_driver_if.master bus
);
    localparam int              CNT_W      = 16;
    localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [CNT_W-1:0] LATCH_LAST = 16'd1;
    localparam logic [CNT_W-1:0] ON_BASE    = CNT_W'(BASE_ON);

    typedef enum logic [2:0] {
        F_TOP, F_BOT, F_CAP, CLK_LO, CLK_HI, BLANK, LATCH, DISPLAY
    } state_t;

    state_t           state_r;
    logic [5:0]       col_r;
    logic [4:0]       row_r;
    logic [1:0]       plane_r;
    logic [CNT_W-1:0] cnt_r;
    logic [11:0]      top_r;
    logic             first_r;
    logic [5:0]       rd_x_r;
    logic [5:0]       rd_y_r;
    logic [2:0]       rgb1_r;
    logic [2:0]       rgb2_r;
    logic [4:0]       addr_r;
    logic             pclk_r;
    logic             lat_r;
    logic             oe_n_r;
    logic             fs_r;
    logic [CNT_W-1:0] on_last_s;
    logic [4:0]       row_next_s;

    // Picks the {R,G,B} bits of the current plane out of a 4:4:4 pixel.
    function automatic logic [2:0] plane_bits(input logic [11:0] px, input logic [1:0] p);
        return {px[{2'b10, p}], px[{2'b01, p}], px[{2'b00, p}]};
    endfunction

    // Display length of the current plane and the row that follows it.
    always_comb begin
        on_last_s = (ON_BASE << plane_r) - 16'd1;
        if (plane_r == 2'd3) begin
            row_next_s = row_r + 5'd1;
        end else begin
            row_next_s = row_r;
        end
    end

    // Scan sequencer: fetch pixel pair, shift it out, then blank/latch/display per plane.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= F_TOP;
            col_r   <= 6'd0;
            row_r   <= 5'd0;
            plane_r <= 2'd0;
            cnt_r   <= 16'd0;
            top_r   <= 12'd0;
            first_r <= 1'b1;
            rd_x_r  <= 6'd0;
            rd_y_r  <= 6'd0;
            rgb1_r  <= 3'd0;
            rgb2_r  <= 3'd0;
            addr_r  <= 5'd0;
            pclk_r  <= 1'b0;
            lat_r   <= 1'b0;
            oe_n_r  <= 1'b1;
            fs_r    <= 1'b0;
        end else begin
            case (state_r)
                F_TOP: begin
                    // The first scan after reset spends one extra F_TOP cycle to flag the frame.
                    if (first_r) begin
                        first_r <= 1'b0;
                        fs_r    <= 1'b1;
                    end else begin
                        fs_r    <= 1'b0;
                        rd_y_r  <= {1'b1, row_r};
                        state_r <= F_BOT;
                    end
                end
                F_BOT: begin
                    top_r   <= bus.rd_color;
                    state_r <= F_CAP;
                end
                F_CAP: begin
                    rgb1_r  <= plane_bits(top_r, plane_r);
                    rgb2_r  <= plane_bits(bus.rd_color, plane_r);
                    cnt_r   <= 16'd0;
                    state_r <= CLK_LO;
                end
                CLK_LO: begin
                    if (cnt_r == DIV_LAST) begin
                        cnt_r   <= 16'd0;
                        pclk_r  <= 1'b1;
                        state_r <= CLK_HI;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                CLK_HI: begin
                    if (cnt_r == DIV_LAST) begin
                        cnt_r  <= 16'd0;
                        pclk_r <= 1'b0;
                        if (col_r == 6'd63) begin
                            col_r   <= 6'd0;
                            addr_r  <= row_r;
                            state_r <= BLANK;
                        end else begin
                            col_r   <= col_r + 6'd1;
                            rd_x_r  <= col_r + 6'd1;
                            rd_y_r  <= {1'b0, row_r};
                            state_r <= F_TOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                BLANK: begin
                    if (cnt_r == BLANK_LAST) begin
                        cnt_r   <= 16'd0;
                        lat_r   <= 1'b1;
                        state_r <= LATCH;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                LATCH: begin
                    if (cnt_r == LATCH_LAST) begin
                        cnt_r   <= 16'd0;
                        lat_r   <= 1'b0;
                        oe_n_r  <= 1'b0;
                        state_r <= DISPLAY;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                DISPLAY: begin
                    if (cnt_r == on_last_s) begin
                        cnt_r   <= 16'd0;
                        oe_n_r  <= 1'b1;
                        plane_r <= plane_r + 2'd1;
                        row_r   <= row_next_s;
                        rd_x_r  <= 6'd0;
                        rd_y_r  <= {1'b0, row_next_s};
                        fs_r    <= (plane_r == 2'd3) && (row_r == 5'd31);
                        state_r <= F_TOP;
                    end else begin
                        cnt_r <= cnt_r + 16'd1;
                    end
                end
                default: begin
                    cnt_r   <= 16'd0;
                    pclk_r  <= 1'b0;
                    lat_r   <= 1'b0;
                    oe_n_r  <= 1'b1;
                    state_r <= F_TOP;
                end
            endcase
        end
    end

    assign bus.rd_x        = rd_x_r;
    assign bus.rd_y        = rd_y_r;
    assign bus.r1          = rgb1_r[2];
    assign bus.g1          = rgb1_r[1];
    assign bus.b1          = rgb1_r[0];
    assign bus.r2          = rgb2_r[2];
    assign bus.g2          = rgb2_r[1];
    assign bus.b2          = rgb2_r[0];
    assign bus.addr        = addr_r;
    assign bus.panel_clk   = pclk_r;
    assign bus.panel_lat   = lat_r;
    assign bus.panel_oe_n  = oe_n_r;
    assign bus.frame_start = fs_r;
endmodule

// File: tb/tb_hub75_scan_driver.sv
// Directed bench for hub75_scan_driver: a default-parameter instance for row/plane
// detail and a fast-parameter instance for the full-frame wrap.
module tb_hub75_scan_driver;
    logic clk  = 1'b0;
    logic rst1 = 1'b1;
    logic rst2 = 1'b1;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    logic [11:0] fb [0:4095];
    logic [11:0] top;
    logic [11:0] bot;

    hub75_scan_driver_if bus1 ();
    hub75_scan_driver_if bus2 ();

    hub75_scan_driver dut1 (.clk(clk), .reset(rst1), .bus(bus1));
    hub75_scan_driver #(.CLK_DIV(1), .BASE_ON(1), .BLANK_CYCLES(1)) dut2 (.clk(clk), .reset(rst2), .bus(bus2));

    always #5 clk = ~clk;

    // Framebuffer with one cycle of read latency for both instances.
    always @(posedge clk) begin
        bus1.rd_color <= fb[{bus1.rd_y, bus1.rd_x}];
        bus2.rd_color <= fb[{bus2.rd_y, bus2.rd_x}];
    end

    int   pclk1_cnt = 0;
    int   oe1_run   = 0;
    int   viol1     = 0;
    int   viol2     = 0;
    int   disp2     = 0;
    int   fs2_cnt   = 0;
    int   pclk1_q[$];
    int   oe1_q[$];
    int   addr2_q[$];
    logic pclk1_prev = 1'b0;
    logic lat1_prev  = 1'b0;
    logic lat2_prev  = 1'b0;
    logic oe2_prev   = 1'b1;
    logic [4:0] addr1_prev = 5'd0;
    logic [4:0] addr2_prev = 5'd0;

    // Passive observers of panel timing, sampled on the falling edge.
    always @(negedge clk) begin
        if (bus1.panel_lat && !lat1_prev) begin
            pclk1_q.push_back(pclk1_cnt);
            pclk1_cnt <= 0;
        end else if (bus1.panel_clk && !pclk1_prev) begin
            pclk1_cnt <= pclk1_cnt + 1;
        end
        if (!bus1.panel_oe_n) begin
            oe1_run <= oe1_run + 1;
        end else if (oe1_run != 0) begin
            oe1_q.push_back(oe1_run);
            oe1_run <= 0;
        end
        if (!bus1.panel_oe_n && (bus1.panel_lat || bus1.panel_clk || bus1.addr != addr1_prev))
            viol1 <= viol1 + 1;
        if (!bus2.panel_oe_n && (bus2.panel_lat || bus2.panel_clk || bus2.addr != addr2_prev))
            viol2 <= viol2 + 1;
        if (bus2.panel_lat && !lat2_prev) addr2_q.push_back(int'(bus2.addr));
        if (!bus2.panel_oe_n && oe2_prev) disp2 <= disp2 + 1;
        if (bus2.frame_start) fs2_cnt <= fs2_cnt + 1;
        pclk1_prev <= bus1.panel_clk;
        lat1_prev  <= bus1.panel_lat;
        lat2_prev  <= bus2.panel_lat;
        oe2_prev   <= bus2.panel_oe_n;
        addr1_prev <= bus1.addr;
        addr2_prev <= bus2.addr;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_to(input int target);
        while (cyc < target) tick();
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) fb[i] = 12'((i * 2731 + 1234) % 4096);
        fb[12'h005] = 12'hA53;
        fb[12'h805] = 12'h5AC;

        repeat (3) @(posedge clk);
        #1;
        check("rst_oe_n", 32'(bus1.panel_oe_n), 32'd1);
        check("rst_pclk", 32'(bus1.panel_clk), 32'd0);
        check("rst_lat", 32'(bus1.panel_lat), 32'd0);
        check("rst_rgb", 32'({bus1.r1, bus1.g1, bus1.b1, bus1.r2, bus1.g2, bus1.b2}), 32'd0);
        check("rst_addr", 32'(bus1.addr), 32'd0);
        check("rst_rd", 32'({bus1.rd_x, bus1.rd_y}), 32'd0);
        check("rst_fs", 32'(bus1.frame_start), 32'd0);

        rst1 = 1'b0;
        rst2 = 1'b0;
        tick();

        // Row 0, plane 0: one column every 7 cycles.
        for (int c = 0; c < 64; c++) begin
            top = fb[12'(c)];
            bot = fb[12'(c + 2048)];
            for (int k = 0; k < 7; k++) begin
                if (k == 0) begin
                    check("rd_x_top", 32'(bus1.rd_x), 32'(c));
                    check("rd_y_top", 32'(bus1.rd_y), 32'd0);
                    check("frame_start", 32'(bus1.frame_start), (c == 0) ? 32'd1 : 32'd0);
                end else if (k == 1) begin
                    check("rd_x_bot", 32'(bus1.rd_x), 32'(c));
                    check("rd_y_bot", 32'(bus1.rd_y), 32'd32);
                end else if (k == 3) begin
                    check("pclk_lo", 32'(bus1.panel_clk), 32'd0);
                end else if (k == 5) begin
                    check("pclk_hi", 32'(bus1.panel_clk), 32'd1);
                    check("rgb1_p0", 32'({bus1.r1, bus1.g1, bus1.b1}), 32'({top[8], top[4], top[0]}));
                    check("rgb2_p0", 32'({bus1.r2, bus1.g2, bus1.b2}), 32'({bot[8], bot[4], bot[0]}));
                    if (c == 5) begin
                        check("px5_top_p0", 32'({bus1.r1, bus1.g1, bus1.b1}), 32'd3);
                        check("px5_bot_p0", 32'({bus1.r2, bus1.g2, bus1.b2}), 32'd4);
                    end
                end
                tick();
            end
        end

        for (int i = 0; i < 4; i++) begin
            check("blank_lat", 32'(bus1.panel_lat), 32'd0);
            check("blank_oe", 32'(bus1.panel_oe_n), 32'd1);
            check("blank_pclk", 32'(bus1.panel_clk), 32'd0);
            tick();
        end
        for (int i = 0; i < 2; i++) begin
            check("latch_lat", 32'(bus1.panel_lat), 32'd1);
            check("latch_oe", 32'(bus1.panel_oe_n), 32'd1);
            tick();
        end
        check("disp_oe", 32'(bus1.panel_oe_n), 32'd0);
        check("disp_lat", 32'(bus1.panel_lat), 32'd0);

        // Plane 3 starts at cycle 1811; column 5 clocks high 40 cycles later.
        wait_to(1851);
        check("pclk_hi_p3", 32'(bus1.panel_clk), 32'd1);
        check("px5_top_p3", 32'({bus1.r1, bus1.g1, bus1.b1}), 32'd4);
        check("px5_bot_p3", 32'({bus1.r2, bus1.g2, bus1.b2}), 32'd3);

        wait_to(2777);
        check("row1_rd_x", 32'(bus1.rd_x), 32'd0);
        check("row1_rd_y", 32'(bus1.rd_y), 32'd1);
        check("row1_fs", 32'(bus1.frame_start), 32'd0);
        tick();
        check("oe_runs", 32'(oe1_q.size()), 32'd4);
        check("latches", 32'(pclk1_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            check("oe_width", 32'(oe1_q[i]), 32'(64 << i));
            check("pclk_per_latch", 32'(pclk1_q[i]), 32'd64);
        end

        for (int n = 0; n < 1000 && bus1.panel_oe_n; n++) tick();
        check("row1_disp", 32'(bus1.panel_oe_n), 32'd0);
        check("row1_addr", 32'(bus1.addr), 32'd1);

        // Reset in the middle of DISPLAY must blank the panel at once.
        repeat (10) tick();
        rst1 = 1'b1;
        #1;
        check("mid_rst_oe", 32'(bus1.panel_oe_n), 32'd1);
        check("mid_rst_lat", 32'(bus1.panel_lat), 32'd0);
        check("mid_rst_pclk", 32'(bus1.panel_clk), 32'd0);
        check("mid_rst_rgb", 32'({bus1.r1, bus1.g1, bus1.b1, bus1.r2, bus1.g2, bus1.b2}), 32'd0);
        check("mid_rst_addr", 32'(bus1.addr), 32'd0);
        check("mid_rst_rd", 32'({bus1.rd_x, bus1.rd_y}), 32'd0);
        check("mid_rst_fs", 32'(bus1.frame_start), 32'd0);
        @(posedge clk);
        #1;
        rst1 = 1'b0;
        tick();
        check("rel_fs", 32'(bus1.frame_start), 32'd1);
        check("rel_rd", 32'({bus1.rd_x, bus1.rd_y}), 32'd0);
        tick();
        check("rel_fs_clear", 32'(bus1.frame_start), 32'd0);
        check("rel_rd_y_bot", 32'(bus1.rd_y), 32'd32);

        // Fast instance: 128 display phases, then a single frame_start.
        for (int n = 0; n < 50000 && !bus2.frame_start; n++) tick();
        check("wrap_fs", 32'(bus2.frame_start), 32'd1);
        check("wrap_phases", 32'(disp2), 32'd128);
        check("wrap_rd", 32'({bus2.rd_x, bus2.rd_y}), 32'd0);
        tick();
        check("wrap_fs_clear", 32'(bus2.frame_start), 32'd0);
        check("wrap_fs_pulses", 32'(fs2_cnt), 32'd2);
        check("wrap_latches", 32'(addr2_q.size()), 32'd128);
        for (int i = 0; i < 128; i++) check("addr_seq", 32'(addr2_q[i]), 32'(i / 4));
        for (int n = 0; n < 400 && addr2_q.size() < 129; n++) tick();
        check("addr_wrap", 32'(addr2_q[128]), 32'd0);

        check("ordering_dut1", 32'(viol1), 32'd0);
        check("ordering_dut2", 32'(viol2), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
